// File: rtl/lfsr_defs.sv
// Shared definitions for the Galois LFSR generator: default geometry and the
// next-state function used by both the RTL and any reference model.
package lfsr_defs;

    localparam int          MAX_WIDTH = 32;
    localparam int          DEF_WIDTH = 10;
    localparam logic [31:0] DEF_TAPS  = 32'h0000_0358;
    localparam logic [31:0] DEF_SEED  = 32'h0000_00E9;

    // One Galois step of a width-bit register held in the low bits of state.
    // Bits at and above width are returned as zero; taps[0] has no effect.
    function automatic logic [MAX_WIDTH-1:0] galois_next(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps,
        input int                   width
    );
        logic                 msb;
        logic [MAX_WIDTH-1:0] nxt;
        msb = 1'b0;
        nxt = '0;
        for (int k = 0; k < MAX_WIDTH; k++) begin
            if (k == width - 1) msb = state[k];
        end
        nxt[0] = msb;
        for (int k = 1; k < MAX_WIDTH; k++) begin
            if (k < width) nxt[k] = state[k-1] ^ (taps[k] & msb);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_galois_gen_if.sv
// Control and observation bundle of the Galois LFSR generator.
// The master side drives step/load requests; the slave side is the generator.
interface lfsr_galois_gen_if
    import lfsr_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] q;
    logic             bit_out;
    logic             lockup;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             period_valid;

    modport master (
        output en, load, seed,
        input  q, bit_out, lockup, wrap, period, period_valid
    );

    modport slave (
        input  en, load, seed,
        output q, bit_out, lockup, wrap, period, period_valid
    );

endinterface

// File: rtl/lfsr_period_cnt.sv
// Period measurement for the LFSR: counts steps since the reference state
// and publishes the cycle length each time the state returns to it.
module lfsr_period_cnt
    import lfsr_defs::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             step,
    input  logic             restart,
    input  logic [WIDTH-1:0] next_state,
    input  logic [WIDTH-1:0] restart_value,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ref_state;
    logic             hit;

    assign hit = (next_state == ref_state);

    // cnt is WIDTH bits: the longest cycle of a non-zero state is 2^WIDTH-1,
    // so cnt+1 at the wrap step always fits.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ref_state    <= SEED;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (restart) begin
                ref_state    <= restart_value;
                cnt          <= '0;
                period_valid <= 1'b0;
            end else if (step) begin
                if (hit) begin
                    period       <= cnt + 1'b1;
                    period_valid <= 1'b1;
                    wrap         <= 1'b1;
                    cnt          <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lfsr_galois_gen.sv
// Parametrised Galois LFSR with step enable, seed load with lock-up
// protection and hardware period measurement.
module lfsr_galois_gen
    import lfsr_defs::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS[WIDTH-1:0],
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst_b,
    lfsr_galois_gen_if.slave bus
);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("lfsr_galois_gen: WIDTH must be in 2..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_galois_gen: SEED must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] load_value;
    logic             seed_zero;
    logic             lockup_r;
    logic             step;

    assign next_state = WIDTH'(galois_next(MAX_WIDTH'(q_r), MAX_WIDTH'(TAPS), WIDTH));

    // A zero seed would lock the register at zero forever; substitute SEED.
    assign seed_zero  = (bus.seed == '0);
    assign load_value = seed_zero ? SEED : bus.seed;
    assign step       = bus.en & ~bus.load;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_r      <= SEED;
            lockup_r <= 1'b0;
        end else begin
            lockup_r <= bus.load & seed_zero;
            if (bus.load) begin
                q_r <= load_value;
            end else if (bus.en) begin
                q_r <= next_state;
            end
        end
    end

    lfsr_period_cnt #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_period_cnt (
        .clk           (clk),
        .rst_b         (rst_b),
        .step          (step),
        .restart       (bus.load),
        .next_state    (next_state),
        .restart_value (load_value),
        .period        (bus.period),
        .period_valid  (bus.period_valid),
        .wrap          (bus.wrap)
    );

    assign bus.q       = q_r;
    assign bus.bit_out = q_r[WIDTH-1];
    assign bus.lockup  = lockup_r;

endmodule
